// File: rtl/input_debouncer_if.sv
// input_debouncer_if
//   Groups the debouncer's data-side signals so the block and its users
//   connect through one port.
//   master : drives data_in / glitch_clr, observes the debounced outputs.
//   slave  : the debouncer itself.
//   data_in      - synchronized raw input bit
//   glitch_clr   - synchronous clear of glitch_count
//   level_out    - debounced level
//   rise_out     - one-cycle pulse after level_out goes 0->1
//   fall_out     - one-cycle pulse after level_out goes 1->0
//   glitch_count - saturating count of aborted transitions
interface input_debouncer_if #(
    parameter int GLITCH_WIDTH = 8
);
    logic                    data_in;
    logic                    glitch_clr;
    logic                    level_out;
    logic                    rise_out;
    logic                    fall_out;
    logic [GLITCH_WIDTH-1:0] glitch_count;

    modport master (
        output data_in, glitch_clr,
        input  level_out, rise_out, fall_out, glitch_count
    );

    modport slave (
        input  data_in, glitch_clr,
        output level_out, rise_out, fall_out, glitch_count
    );
endinterface

// File: rtl/input_debouncer.sv
// input_debouncer
//   Debounces a single synchronized input bit. The output level flips only
//   after DEBOUNCE_CYCLES consecutive samples disagree with it; a mismatch
//   run that ends early is counted as a glitch.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - asynchronous, active-high reset
//   bus   - input_debouncer_if.slave (data_in, glitch_clr in;
//           level_out, rise_out, fall_out, glitch_count out)
module input_debouncer #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_LEVEL     = 1'b0,
    parameter int   GLITCH_WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input_debouncer_if.slave    bus
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_DONE = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic                    glitch;
    logic                    level_q, level_d;
    logic                    rise_q, fall_q;
    logic [GLITCH_WIDTH-1:0] glitch_q;

    // Counter only runs inside WAIT states, where it is at most
    // DEBOUNCE_CYCLES-1, so the increment cannot overflow CW bits.
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        glitch  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (bus.data_in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HIGH;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (bus.data_in) begin
                    // >= rather than == so a corrupted count still terminates
                    if (cnt_inc >= CNT_DONE) begin
                        state_d = STABLE_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!bus.data_in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_LOW;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_LOW: begin
                if (!bus.data_in) begin
                    if (cnt_inc >= CNT_DONE) begin
                        state_d = STABLE_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // Level is high in the states that represent a settled or pending-low
    // high level; registered alongside the state so it is glitch-free.
    assign level_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    // Clear has priority over a same-edge glitch; count sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_q <= '0;
        end else if (bus.glitch_clr) begin
            glitch_q <= '0;
        end else if (glitch && (glitch_q != {GLITCH_WIDTH{1'b1}})) begin
            glitch_q <= glitch_q + GLITCH_WIDTH'(1);
        end
    end

    assign bus.level_out    = level_q;
    assign bus.rise_out     = rise_q;
    assign bus.fall_out     = fall_q;
    assign bus.glitch_count = glitch_q;
endmodule
